// File: rtl/teclado_pkg.sv
// Shared key codes, FSM state encoding and helpers for the keypad entry block.
package teclado_pkg;

  // Key codes delivered by the keypad scanner
  localparam logic [4:0] TECLA_NADA    = 5'd16;
  localparam logic [4:0] TECLA_BORRAR  = 5'd10;  // A: backspace
  localparam logic [4:0] TECLA_LIMPIAR = 5'd12;  // C: clear
  localparam logic [4:0] TECLA_ENTER   = 5'd13;  // D: enter
  localparam logic [4:0] MAX_DIGITO    = 5'd9;

  // FSM state encoding
  localparam logic [1:0] StEdit = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Largest decimal value representable with the given number of digits (10^n - 1)
  function automatic int unsigned max_valor(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/teclado_bcd_a_bin.sv
// Serial BCD to binary converter: one decimal digit per cycle, most significant first,
// using acc = acc*10 + digit. 'done' flags the cycle in which the last digit is folded in,
// with the final value already present on 'result'.
module teclado_bcd_a_bin
  import teclado_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [4*DIGITS-1:0]            bcd,
  input  logic [$clog2(DIGITS+1)-1:0]    count,
  output logic [BIN_W-1:0]               result,
  output logic                           done
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);

  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [3:0]       nib;

  // Current digit, its accumulation and the last-digit flag
  always_comb begin
    nib    = bcd[{idx_q, 2'b00} +: 4];
    result = (acc_q << 3) + (acc_q << 1) + {{(BIN_W-4){1'b0}}, nib};
    done   = busy_q && (idx_q == '0);
  end

  // Load on start, then walk the index down to nibble 0
  always_comb begin
    acc_d  = acc_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (start) begin
      acc_d  = '0;
      idx_d  = count - CntW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = result;
      idx_d  = idx_q - CntW'(1);
      busy_d = (idx_q != '0);
    end
  end

  // Converter state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/teclado_entrada.sv
// Keypad entry: edits a BCD buffer from scanner key strobes and, on enter, converts it to
// binary and emits a one-cycle valid pulse.
// Optional idle auto-clear enabled by defining TECLADO_ENTRADA_TIMEOUT_EN.
module teclado_entrada
  import teclado_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned TIMEOUT_CYC = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4:0]                  digito,
  input  logic                        cambio_digito,
  output logic [4*DIGITS-1:0]         bcd_out,
  output logic [$clog2(DIGITS+1)-1:0] cant_digitos,
  output logic [BIN_W-1:0]            dato_bin,
  output logic                        dato_valido,
  output logic                        ocupado,
  output logic                        error
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  logic [1:0]       state_q, state_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             val_q, val_d;
  logic             err_q, err_d;
  logic             start;
  logic             key_acc;
  logic             expire;
  logic [BIN_W-1:0] result;
  logic             done;

  // A key counts as accepted only in EDIT and only for digits, A, C and D
  assign key_acc = cambio_digito && (state_q == StEdit) &&
                   ((digito <= MAX_DIGITO) || (digito == TECLA_BORRAR) ||
                    (digito == TECLA_LIMPIAR) || (digito == TECLA_ENTER));

  teclado_bcd_a_bin #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd    (bcd_q),
    .count  (cnt_q),
    .result (result),
    .done   (done)
  );

`ifdef TECLADO_ENTRADA_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] idle_q, idle_d;

  // Idle counter: runs only while editing a non-empty buffer; any accepted key wins
  always_comb begin
    expire = 1'b0;
    idle_d = '0;
    if ((state_q == StEdit) && (cnt_q != '0) && !key_acc) begin
      if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
        expire = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Edit buffer and FSM next-state
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    start   = 1'b0;
    case (state_q)
      StEdit: begin
        if (expire) begin
          bcd_d = '0;
          cnt_d = '0;
        end
        if (key_acc) begin
          if (digito <= MAX_DIGITO) begin
            if (cnt_q < CntW'(DIGITS)) begin
              bcd_d = (bcd_q << 4) | BcdW'(digito[3:0]);
              cnt_d = cnt_q + CntW'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (digito == TECLA_BORRAR) begin
            if (cnt_q != '0) begin
              bcd_d = bcd_q >> 4;
              cnt_d = cnt_q - CntW'(1);
            end
          end else if (digito == TECLA_LIMPIAR) begin
            bcd_d = '0;
            cnt_d = '0;
          end else begin
            if (cnt_q == '0) begin
              err_d = 1'b1;
            end else begin
              start   = 1'b1;
              state_d = StConv;
            end
          end
        end
      end
      StConv: begin
        if (done) begin
          state_d = StDone;
          bin_d   = result;
          val_d   = 1'b1;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      StDone:  state_d = StEdit;
      default: state_d = StEdit;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEdit;
      bcd_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out      = bcd_q;
  assign cant_digitos = cnt_q;
  assign dato_bin     = bin_q;
  assign dato_valido  = val_q;
  assign error        = err_q;
  assign ocupado      = (state_q != StEdit);

endmodule

// File: tb/tb_teclado_entrada.sv
// Self-checking bench for teclado_entrada: directed scenarios plus randomized keys checked
// against a digit-list reference model.
module tb_teclado_entrada;
  import teclado_pkg::*;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned TO     = 8;
  localparam int unsigned CntW   = $clog2(DIGITS + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cambio_digito = 1'b0;
  logic [4:0]            digito = TECLA_NADA;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [CntW-1:0]       cant_digitos;
  logic [BIN_W-1:0]      dato_bin;
  logic                  dato_valido;
  logic                  ocupado;
  logic                  error;

  int checks = 0;
  int errors = 0;

  // Reference model: digits oldest-first, remaining busy cycles, results
  int m_q[$];
  int m_busy = 0;
  int m_conv = 0;
  int m_bin  = 0;
  int m_idle = 0;
  bit m_val  = 1'b0;
  bit m_err  = 1'b0;

  teclado_entrada #(
    .DIGITS      (DIGITS),
    .BIN_W       (BIN_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .bcd_out       (bcd_out),
    .cant_digitos  (cant_digitos),
    .dato_bin      (dato_bin),
    .dato_valido   (dato_valido),
    .ocupado       (ocupado),
    .error         (error)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] model_bcd();
    logic [4*DIGITS-1:0] b;
    b = '0;
    foreach (m_q[i]) b = (b << 4) | (4*DIGITS)'(m_q[i]);
    return b;
  endfunction

  // Apply one cycle of stimulus, advance the model, and leave time at edge+1
  task automatic tick(input bit s, input logic [4:0] k, input bit r);
    bit acc;
    int v;
    cambio_digito = s;
    digito        = k;
    rst_n         = !r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_busy = 0; m_bin = 0; m_val = 0; m_err = 0; m_idle = 0;
    end else begin
      m_val = 0;
      m_err = 0;
      if (m_busy > 0) begin
        m_idle = 0;
        if (m_busy == 2) begin
          m_bin = m_conv;
          m_val = 1;
          m_q.delete();
        end
        m_busy--;
      end else begin
        acc = s && (k <= 9 || k == TECLA_BORRAR || k == TECLA_LIMPIAR || k == TECLA_ENTER);
`ifdef TECLADO_ENTRADA_TIMEOUT_EN
        if (acc) m_idle = 0;
        else if (m_q.size() > 0) begin
          if (m_idle == TO - 1) begin
            m_q.delete();
            m_idle = 0;
          end else m_idle++;
        end else m_idle = 0;
`endif
        if (acc) begin
          if (k <= 9) begin
            if (m_q.size() < DIGITS) m_q.push_back(int'(k));
            else m_err = 1;
          end else if (k == TECLA_BORRAR) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
          end else if (k == TECLA_LIMPIAR) begin
            m_q.delete();
          end else begin
            if (m_q.size() == 0) m_err = 1;
            else begin
              v = 0;
              foreach (m_q[i]) v = v * 10 + m_q[i];
              m_conv = v % (1 << BIN_W);
              m_busy = m_q.size() + 1;
            end
          end
        end
      end
    end
    #1;
    cambio_digito = 1'b0;
    digito        = TECLA_NADA;
    rst_n         = 1'b1;
  endtask

  task automatic test_reset();
    tick(1'b0, TECLA_NADA, 1'b1);
    checks++;
    if ({bcd_out, cant_digitos, dato_bin, dato_valido, ocupado, error} !== '0) begin
      errors++;
      $display("FAIL reset: got bcd=%h cnt=%0d bin=%0d v=%b o=%b e=%b, want all zero",
               bcd_out, cant_digitos, dato_bin, dato_valido, ocupado, error);
    end
  endtask

  task automatic test_entry();
    int ocup, vcnt, seen;
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    for (int i = 1; i <= 4; i++) tick(1'b1, 5'(i), 1'b0);
    checks++;
    if (bcd_out !== 16'h1234) begin
      errors++; $display("FAIL entry_bcd: got %h want 1234", bcd_out);
    end
    checks++;
    if (cant_digitos !== 3'd4) begin
      errors++; $display("FAIL entry_cnt: got %0d want 4", cant_digitos);
    end
    tick(1'b1, TECLA_ENTER, 1'b0);
    ocup = ocupado ? 1 : 0;
    vcnt = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, TECLA_NADA, 1'b0);
      if (ocupado) ocup++;
      if (dato_valido) begin vcnt++; seen = int'(dato_bin); end
    end
    checks++;
    if (ocup != 5) begin errors++; $display("FAIL entry_busy: got %0d want 5", ocup); end
    checks++;
    if (vcnt != 1) begin errors++; $display("FAIL entry_pulses: got %0d want 1", vcnt); end
    checks++;
    if (seen != 1234) begin errors++; $display("FAIL entry_bin: got %0d want 1234", seen); end
    checks++;
    if (bcd_out !== '0 || cant_digitos !== '0) begin
      errors++; $display("FAIL entry_clear: got bcd=%h cnt=%0d want 0 0", bcd_out, cant_digitos);
    end
  endtask

  task automatic test_full();
    int lat;
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 5'd9, 1'b0);
    tick(1'b1, 5'd5, 1'b0);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL full_err: got %b want 1", error); end
    checks++;
    if (bcd_out !== 16'h9999) begin errors++; $display("FAIL full_bcd: got %h want 9999", bcd_out); end
    tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL full_err_len: got %b want 0", error); end
    tick(1'b1, TECLA_ENTER, 1'b0);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, TECLA_NADA, 1'b0);
      if (dato_valido) begin lat = i; break; end
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL full_latency: got %0d want 4", lat); end
    checks++;
    if (int'(dato_bin) != int'(max_valor(DIGITS))) begin
      errors++; $display("FAIL full_bin: got %0d want %0d", dato_bin, max_valor(DIGITS));
    end
    tick(1'b0, TECLA_NADA, 1'b0);
  endtask

  task automatic test_backspace();
    int lat;
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    tick(1'b1, 5'd7, 1'b0);
    tick(1'b1, 5'd8, 1'b0);
    checks++;
    if (bcd_out !== 16'h0078) begin errors++; $display("FAIL bs_78: got %h want 0078", bcd_out); end
    tick(1'b1, TECLA_BORRAR, 1'b0);
    checks++;
    if (bcd_out !== 16'h0007) begin errors++; $display("FAIL bs_7: got %h want 0007", bcd_out); end
    tick(1'b1, 5'd5, 1'b0);
    checks++;
    if (bcd_out !== 16'h0075) begin errors++; $display("FAIL bs_75: got %h want 0075", bcd_out); end
    tick(1'b1, TECLA_ENTER, 1'b0);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, TECLA_NADA, 1'b0);
      if (dato_valido) begin lat = i; break; end
    end
    checks++;
    if (lat != 2 || dato_bin !== 14'd75) begin
      errors++; $display("FAIL bs_conv: got lat=%0d bin=%0d want 2 75", lat, dato_bin);
    end
    tick(1'b0, TECLA_NADA, 1'b0);
    tick(1'b1, TECLA_BORRAR, 1'b0);
    checks++;
    if (bcd_out !== '0 || cant_digitos !== '0 || error !== 1'b0) begin
      errors++; $display("FAIL bs_empty: got bcd=%h cnt=%0d e=%b want 0 0 0",
                         bcd_out, cant_digitos, error);
    end
  endtask

  task automatic test_ignored();
    logic [4:0] ign [4];
    ign[0] = TECLA_NADA; ign[1] = 5'd11; ign[2] = 5'd14; ign[3] = 5'd15;
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    tick(1'b1, TECLA_ENTER, 1'b0);
    checks++;
    if (error !== 1'b1 || ocupado !== 1'b0) begin
      errors++; $display("FAIL empty_enter: got e=%b o=%b want 1 0", error, ocupado);
    end
    tick(1'b1, 5'd5, 1'b0);
    foreach (ign[j]) begin
      tick(1'b1, ign[j], 1'b0);
      checks++;
      if (bcd_out !== 16'h0005 || cant_digitos !== 3'd1 || error !== 1'b0) begin
        errors++; $display("FAIL ignored_key_%0d: got bcd=%h cnt=%0d e=%b want 0005 1 0",
                           ign[j], bcd_out, cant_digitos, error);
      end
    end
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    tick(1'b1, 5'd8, 1'b0);
    tick(1'b1, 5'd1, 1'b0);
    tick(1'b1, TECLA_ENTER, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick((i == 1), 5'd3, 1'b0);
      if (dato_valido) break;
    end
    checks++;
    if (dato_bin !== 14'd81) begin errors++; $display("FAIL busy_key_bin: got %0d want 81", dato_bin); end
    tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (bcd_out !== '0 || cant_digitos !== '0) begin
      errors++; $display("FAIL busy_key_dropped: got bcd=%h cnt=%0d want 0 0", bcd_out, cant_digitos);
    end
    tick(1'b1, 5'd3, 1'b0);
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    checks++;
    if (bcd_out !== '0 || cant_digitos !== '0) begin
      errors++; $display("FAIL clear: got bcd=%h cnt=%0d want 0 0", bcd_out, cant_digitos);
    end
  endtask

  task automatic test_reset_conv();
    int vseen, lat;
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    tick(1'b1, 5'd4, 1'b0);
    tick(1'b1, 5'd5, 1'b0);
    tick(1'b1, 5'd6, 1'b0);
    tick(1'b1, TECLA_ENTER, 1'b0);
    tick(1'b0, TECLA_NADA, 1'b0);
    tick(1'b0, TECLA_NADA, 1'b1);
    checks++;
    if ({bcd_out, cant_digitos, dato_bin, dato_valido, ocupado, error} !== '0) begin
      errors++; $display("FAIL abort: got bcd=%h cnt=%0d bin=%0d v=%b o=%b want all zero",
                         bcd_out, cant_digitos, dato_bin, dato_valido, ocupado);
    end
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, TECLA_NADA, 1'b0);
      if (dato_valido || ocupado) vseen++;
    end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", vseen); end
    tick(1'b1, 5'd2, 1'b0);
    tick(1'b1, TECLA_ENTER, 1'b0);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, TECLA_NADA, 1'b0);
      if (dato_valido) begin lat = i; break; end
    end
    checks++;
    if (lat != 1 || dato_bin !== 14'd2) begin
      errors++; $display("FAIL after_abort: got lat=%0d bin=%0d want 1 2", lat, dato_bin);
    end
    tick(1'b0, TECLA_NADA, 1'b0);
  endtask

  task automatic test_timeout();
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
    tick(1'b1, 5'd6, 1'b0);
`ifdef TECLADO_ENTRADA_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (bcd_out !== 16'h0006) begin errors++; $display("FAIL to_hold: got %h want 0006", bcd_out); end
    tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (bcd_out !== '0 || cant_digitos !== '0 || error !== 1'b0) begin
      errors++; $display("FAIL to_expire: got bcd=%h cnt=%0d e=%b want 0 0 0",
                         bcd_out, cant_digitos, error);
    end
    tick(1'b1, 5'd6, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, TECLA_NADA, 1'b0);
    tick(1'b1, 5'd1, 1'b0);
    checks++;
    if (bcd_out !== 16'h0061 || cant_digitos !== 3'd2) begin
      errors++; $display("FAIL to_key_wins: got bcd=%h cnt=%0d want 0061 2", bcd_out, cant_digitos);
    end
    for (int i = 0; i < TO - 1; i++) tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (bcd_out !== 16'h0061) begin errors++; $display("FAIL to_reload: got %h want 0061", bcd_out); end
`else
    for (int i = 0; i < 1000; i++) tick(1'b0, TECLA_NADA, 1'b0);
    checks++;
    if (bcd_out !== 16'h0006 || cant_digitos !== 3'd1) begin
      errors++; $display("FAIL persist: got bcd=%h cnt=%0d want 0006 1", bcd_out, cant_digitos);
    end
`endif
    tick(1'b1, TECLA_LIMPIAR, 1'b0);
  endtask

  task automatic test_random();
    int r;
    bit s, rs;
    logic [4:0] k;
    for (int n = 0; n < 800; n++) begin
      r  = int'($urandom_range(0, 99));
      if (r < 60)      k = 5'($urandom_range(0, 9));
      else if (r < 75) k = TECLA_ENTER;
      else if (r < 84) k = TECLA_BORRAR;
      else if (r < 88) k = TECLA_LIMPIAR;
      else             k = 5'($urandom_range(10, 16));
      s  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 299) == 0);
      tick(s, k, rs);
      checks++;
      if (bcd_out !== model_bcd() || int'(cant_digitos) != m_q.size() ||
          int'(dato_bin) != m_bin || dato_valido !== m_val || error !== m_err ||
          ocupado !== (m_busy > 0)) begin
        errors++;
        $display("FAIL random_%0d: got bcd=%h cnt=%0d bin=%0d v=%b e=%b o=%b want %h %0d %0d %b %b %b",
                 n, bcd_out, cant_digitos, dato_bin, dato_valido, error, ocupado,
                 model_bcd(), m_q.size(), m_bin, m_val, m_err, (m_busy > 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full();
    test_backspace();
    test_ignored();
    test_reset_conv();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
